// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline-stage register.
//   - State encoding of the stage controller (EMPTY / FULL / SKID).
//   - Default widths for data payload, destination index and control bundle.
// No ports (package).
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_DST_W  = 5;
    localparam int PIPE_CTRL_W = 8;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_FULL  = ST_FULL,
        S_SKID  = ST_SKID
    } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one {valid, data, dst, ctrl} holding register.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   load                  capture d_* and mark the slot valid
//   clear                 invalidate the slot (wins over load)
//   d_data/d_dst/d_ctrl   payload to capture
//   q_valid/q_data/...    held entry
// ZERO_ON_CLEAR also wipes the payload on clear; the main slot keeps its
// payload so the downstream data/dst lines hold their last value.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W        = PIPE_DATA_W,
    parameter int DST_W         = PIPE_DST_W,
    parameter int CTRL_W        = PIPE_CTRL_W,
    parameter bit ZERO_ON_CLEAR = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [DST_W-1:0]  d_dst,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [DST_W-1:0]  q_dst,
    output logic [CTRL_W-1:0] q_ctrl
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_dst   <= '0;
            q_ctrl  <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
            if (ZERO_ON_CLEAR) begin
                q_data <= '0;
                q_dst  <= '0;
                q_ctrl <= '0;
            end
        end else if (load) begin
            q_valid <= 1'b1;
            q_data  <= d_data;
            q_dst   <= d_dst;
            q_ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage pipeline register with valid/ready handshake,
// a two-entry skid buffer (main + skid slot) and synchronous flush.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   flush                        squash every held entry this cycle
//   in_valid/in_ready            upstream handshake (in_ready is registered)
//   in_data/in_dst/in_ctrl       upstream entry
//   out_valid/out_ready          downstream handshake
//   out_data/out_dst/out_ctrl    entry to next stage (out_ctrl is 0 when idle)
//   stall_cnt [15:0]             only with PIPE_STALL_CNT_EN defined: saturating
//                                count of cycles with out_valid & !out_ready
// Optional build macro: PIPE_STALL_CNT_EN.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int DST_W  = PIPE_DST_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DST_W-1:0]  in_dst,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DST_W-1:0]  out_dst,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int MAIN = 0;
    localparam int SKID = 1;

    pipe_state_e state_reg, state_next;
    logic        in_ready_reg;
    logic        in_xfer, out_xfer;
    logic        main_from_skid;

    logic [1:0]        slot_load, slot_clear, slot_valid;
    logic [DATA_W-1:0] slot_d_data [2];
    logic [DST_W-1:0]  slot_d_dst  [2];
    logic [CTRL_W-1:0] slot_d_ctrl [2];
    logic [DATA_W-1:0] slot_q_data [2];
    logic [DST_W-1:0]  slot_q_dst  [2];
    logic [CTRL_W-1:0] slot_q_ctrl [2];

    assign in_xfer  = in_valid & in_ready_reg;
    assign out_xfer = slot_valid[MAIN] & out_ready;

    // Main slot refills from the skid slot when draining SKID, otherwise
    // from upstream; the skid slot only ever captures upstream.
    assign slot_d_data[MAIN] = main_from_skid ? slot_q_data[SKID] : in_data;
    assign slot_d_dst[MAIN]  = main_from_skid ? slot_q_dst[SKID]  : in_dst;
    assign slot_d_ctrl[MAIN] = main_from_skid ? slot_q_ctrl[SKID] : in_ctrl;
    assign slot_d_data[SKID] = in_data;
    assign slot_d_dst[SKID]  = in_dst;
    assign slot_d_ctrl[SKID] = in_ctrl;

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        pipe_slot #(
            .DATA_W        (DATA_W),
            .DST_W         (DST_W),
            .CTRL_W        (CTRL_W),
            .ZERO_ON_CLEAR (gi == SKID)
        ) u_slot (
            .clock   (clock),
            .reset   (reset),
            .load    (slot_load[gi]),
            .clear   (slot_clear[gi]),
            .d_data  (slot_d_data[gi]),
            .d_dst   (slot_d_dst[gi]),
            .d_ctrl  (slot_d_ctrl[gi]),
            .q_valid (slot_valid[gi]),
            .q_data  (slot_q_data[gi]),
            .q_dst   (slot_q_dst[gi]),
            .q_ctrl  (slot_q_ctrl[gi])
        );
    end

    always_comb begin
        state_next     = state_reg;
        slot_load      = '0;
        slot_clear     = '0;
        main_from_skid = 1'b0;
        case (state_reg)
            S_EMPTY: begin
                if (in_xfer) begin
                    slot_load[MAIN] = 1'b1;
                    state_next      = S_FULL;
                end
            end
            S_FULL: begin
                if (in_xfer && out_xfer) begin
                    slot_load[MAIN] = 1'b1;
                end else if (in_xfer) begin
                    slot_load[SKID] = 1'b1;
                    state_next      = S_SKID;
                end else if (out_xfer) begin
                    slot_clear[MAIN] = 1'b1;
                    state_next       = S_EMPTY;
                end
            end
            S_SKID: begin
                if (out_xfer && slot_valid[SKID]) begin
                    slot_load[MAIN]  = 1'b1;
                    slot_clear[SKID] = 1'b1;
                    main_from_skid   = 1'b1;
                    state_next       = S_FULL;
                end
            end
            default: state_next = S_EMPTY;
        endcase
        // Flush lands after any output transfer of this cycle and discards
        // whatever upstream offered.
        if (flush) begin
            state_next     = S_EMPTY;
            slot_load      = '0;
            slot_clear     = 2'b11;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= S_EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            // Registered from the next state so in_ready never depends on
            // out_ready combinationally.
            in_ready_reg <= (state_next != S_SKID);
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = slot_valid[MAIN];
    assign out_data  = slot_q_data[MAIN];
    assign out_dst   = slot_q_dst[MAIN];
    assign out_ctrl  = slot_valid[MAIN] ? slot_q_ctrl[MAIN] : '0;

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (slot_valid[MAIN] && !out_ready && stall_cnt_reg != 16'hFFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed vector table plus hand-written sequences for
// pipe_stage_skid (ordering under irregular backpressure, stall counter when
// PIPE_STALL_CNT_EN is defined).
module tb_pipe_stage_skid;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_dst, out_dst;
    logic [7:0]  in_ctrl, out_ctrl;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pipe_stage_skid dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dst    (in_dst),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dst   (out_dst),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic [4:0]  dst;
        logic [7:0]  c;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_d;
        logic [4:0]  e_dst;
        logic [7:0]  e_c;
        logic        e_ir;
    } vec_t;

    vec_t vecs [27];
    int   n_vec = 0;

    task automatic add(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] d, input logic [4:0] dst, input logic [7:0] c,
                       input logic ordy, input logic e_ov, input logic [31:0] e_d,
                       input logic [4:0] e_dst, input logic [7:0] e_c, input logic e_ir);
        vecs[n_vec] = '{rst, fl, iv, d, dst, c, ordy, e_ov, e_d, e_dst, e_c, e_ir};
        n_vec++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int send_seq, recv_seq, cyc;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_dst = '0; in_ctrl = '0;

        //   rst fl iv data          dst  ctrl   ordy | ov data          dst  ctrl   ir
        add(1, 0, 0, 32'h0,         5'd0, 8'h00, 0,   0, 32'h0,         5'd0, 8'h00, 1); // 0 reset
        add(1, 0, 0, 32'h0,         5'd0, 8'h00, 0,   0, 32'h0,         5'd0, 8'h00, 1); // 1 reset
        add(0, 0, 0, 32'h0,         5'd0, 8'h00, 0,   0, 32'h0,         5'd0, 8'h00, 1); // 2 idle
        add(0, 0, 1, 32'd1,         5'd1, 8'h11, 1,   1, 32'd1,         5'd1, 8'h11, 1); // 3 stream
        add(0, 0, 1, 32'd2,         5'd2, 8'h22, 1,   1, 32'd2,         5'd2, 8'h22, 1); // 4
        add(0, 0, 1, 32'd3,         5'd3, 8'h33, 1,   1, 32'd3,         5'd3, 8'h33, 1); // 5
        add(0, 0, 1, 32'd4,         5'd4, 8'h44, 1,   1, 32'd4,         5'd4, 8'h44, 1); // 6
        add(0, 0, 0, 32'h0,         5'd0, 8'h00, 1,   0, 32'd4,         5'd4, 8'h00, 1); // 7 drain
        add(0, 0, 1, 32'hAAAA0000,  5'd5, 8'hA5, 0,   1, 32'hAAAA0000,  5'd5, 8'hA5, 1); // 8 A
        add(0, 0, 1, 32'hBBBB0000,  5'd6, 8'hB6, 0,   1, 32'hAAAA0000,  5'd5, 8'hA5, 0); // 9 B->skid
        add(0, 0, 1, 32'h99999999,  5'd3, 8'h39, 0,   1, 32'hAAAA0000,  5'd5, 8'hA5, 0); // 10 refused
        add(0, 0, 0, 32'h0,         5'd0, 8'h00, 1,   1, 32'hBBBB0000,  5'd6, 8'hB6, 1); // 11 A out
        add(0, 0, 0, 32'h0,         5'd0, 8'h00, 1,   0, 32'hBBBB0000,  5'd6, 8'h00, 1); // 12 B out
        add(0, 0, 1, 32'hAAAA0000,  5'd5, 8'hA5, 0,   1, 32'hAAAA0000,  5'd5, 8'hA5, 1); // 13 A
        add(0, 0, 1, 32'hBBBB0000,  5'd6, 8'hB6, 0,   1, 32'hAAAA0000,  5'd5, 8'hA5, 0); // 14 B
        add(0, 1, 0, 32'h0,         5'd0, 8'h00, 0,   0, 32'hAAAA0000,  5'd5, 8'h00, 1); // 15 flush
        add(0, 0, 1, 32'h12345678,  5'd7, 8'hC7, 0,   1, 32'h12345678,  5'd7, 8'hC7, 1); // 16 C
        add(0, 0, 0, 32'h0,         5'd0, 8'h00, 1,   0, 32'h12345678,  5'd7, 8'h00, 1); // 17 C out
        add(0, 0, 0, 32'h0,         5'd0, 8'h00, 1,   0, 32'h12345678,  5'd7, 8'h00, 1); // 18 no B
        add(0, 1, 1, 32'h0000DEAD,  5'd8, 8'hDE, 1,   0, 32'h12345678,  5'd7, 8'h00, 1); // 19 flush+in
        add(0, 0, 0, 32'h0,         5'd0, 8'h00, 1,   0, 32'h12345678,  5'd7, 8'h00, 1); // 20
        add(0, 0, 1, 32'h00000055,  5'd9, 8'h5A, 0,   1, 32'h00000055,  5'd9, 8'h5A, 1); // 21
        add(0, 1, 1, 32'h00000066,  5'd11,8'h66, 1,   0, 32'h00000055,  5'd9, 8'h00, 1); // 22 flush+out
        add(0, 0, 1, 32'h00000077,  5'd10,8'h77, 0,   1, 32'h00000077,  5'd10,8'h77, 1); // 23
        add(0, 0, 1, 32'h00000088,  5'd12,8'h88, 0,   1, 32'h00000077,  5'd10,8'h77, 0); // 24 skid
        add(1, 1, 1, 32'h00000099,  5'd13,8'h99, 1,   0, 32'h0,         5'd0, 8'h00, 1); // 25 reset+flush
        add(0, 0, 0, 32'h0,         5'd0, 8'h00, 1,   0, 32'h0,         5'd0, 8'h00, 1); // 26

        for (int i = 0; i < n_vec; i++) begin
            reset     = vecs[i].rst;
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            in_dst    = vecs[i].dst;
            in_ctrl   = vecs[i].c;
            out_ready = vecs[i].ordy;
            tick();
            $display("vec %0d: ov=%0d data=%h dst=%0d ctrl=%h ir=%0d",
                     i, out_valid, out_data, out_dst, out_ctrl, in_ready);
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d out_data", i),  out_data,         vecs[i].e_d);
            check($sformatf("vec%0d out_dst", i),   32'(out_dst),     32'(vecs[i].e_dst));
            check($sformatf("vec%0d out_ctrl", i),  32'(out_ctrl),    32'(vecs[i].e_c));
            check($sformatf("vec%0d in_ready", i),  32'(in_ready),    32'(vecs[i].e_ir));
        end

        // Ordering under an irregular ready pattern: words must arrive as
        // 1,2,3,... with matching dst/ctrl, and every accepted word must
        // eventually leave.
        reset = 1'b0; flush = 1'b0;
        send_seq = 1; recv_seq = 1;
        for (cyc = 0; cyc < 80; cyc++) begin
            in_valid  = (cyc < 60);
            in_data   = 32'(send_seq);
            in_dst    = 5'(send_seq);
            in_ctrl   = 8'(send_seq);
            out_ready = (cyc >= 60) || ((cyc % 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                $display("seq recv: data=%h dst=%0d ctrl=%h", out_data, out_dst, out_ctrl);
                check("seq data", out_data,        32'(recv_seq));
                check("seq ctrl", 32'(out_ctrl),   32'(8'(recv_seq)));
                recv_seq++;
            end
            if (in_valid && in_ready) send_seq++;
            tick();
        end
        check("seq out_valid drained", 32'(out_valid), 32'd0);
        check("seq count", 32'(recv_seq), 32'(send_seq));
        check("seq enough traffic", 32'(send_seq > 30), 32'd1);

`ifdef PIPE_STALL_CNT_EN
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("stall after reset", 32'(stall_cnt), 32'd0);
        reset = 1'b0; in_valid = 1'b1; in_data = 32'h5; in_ctrl = 8'h5;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        $display("stall: cnt=%0d after 5 stalled cycles", stall_cnt);
        check("stall count 5", 32'(stall_cnt), 32'd5);
        repeat (70000) tick();
        $display("stall: cnt=%h after long stall", stall_cnt);
        check("stall saturate", 32'(stall_cnt), 32'h0000FFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("stall kept by flush", 32'(stall_cnt), 32'h0000FFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("stall cleared by reset", 32'(stall_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline-stage register for the inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) of the processor.
- Carries a data word, a destination register index and a control bundle between stages.
- Adds a valid/ready handshake, a two-entry skid buffer for full throughput under backpressure, and a synchronous flush for branch squash.

Parameters:
DATA_W, 32, width of data payload (ALU result / branch address field)
DST_W, 5, width of destination register index
CTRL_W, 8, width of control bundle (reg_write, reg_dst, mem_reg_dst, ...)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  squash all held entries this cycle
in_valid  in  1  upstream stage presents an entry
in_ready  out  1  stage can accept an entry this cycle
in_data  in  DATA_W  upstream payload
in_dst  in  DST_W  upstream destination index
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  stage presents an entry downstream
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  payload to next stage
out_dst  out  DST_W  destination index to next stage
out_ctrl  out  CTRL_W  control bundle to next stage; forced 0 when out_valid=0

Behaviour:
- Reset (reset sampled high at clock edge): out_valid=0, out_data=0, out_dst=0, out_ctrl=0, in_ready=1, skid entry empty and zeroed, state=EMPTY.
- in_ready is registered: in_ready = (state != SKID). It has no combinational path from out_ready.
- An input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N.
- States:
  - EMPTY: main slot invalid.
  - FULL: main slot valid, skid slot invalid.
  - SKID: both slots valid.
- Transitions (in = input transfer, out = output transfer):
  - EMPTY: in -> FULL (main loads input).
  - FULL: in & out -> FULL (main reloads). in & !out -> SKID (skid captures input). !in & out -> EMPTY.
  - SKID: out -> FULL (main takes skid contents, skid clears). !out -> SKID (hold). No input transfer is possible in SKID.
- Ordering: entries leave strictly in arrival order. No entry is duplicated or dropped except by flush.
- Flush (synchronous, priority over every load/transfer except reset):
  - Next state is EMPTY; out_valid=0; out_ctrl=0; skid cleared; in_ready=1.
  - An input offered in the same cycle is discarded.
  - An output transfer in the same cycle still counts downstream; the flush is applied after it.
- While out_valid=0, out_data and out_dst hold their last values, but out_ctrl reads 0 so no reg_write leaks.
- reset asserted mid-transfer overrides everything and behaves exactly as reset.
- Simultaneous reset and flush: reset wins; result is identical.

Optional Feature:
PIPE_STALL_CNT_EN
- Defined:
  - Adds output port stall_cnt [15:0].
  - Increments each cycle out_valid & !out_ready, saturating at 16'hFFFF.
  - Cleared by reset; not cleared by flush.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding localparams: ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2.
  - default width constants: PIPE_DATA_W=32, PIPE_DST_W=5, PIPE_CTRL_W=8.
- One sub-module, pipe_slot: a {valid, data, dst, ctrl} register with load enable and clear. It is instantiated twice (main, skid).

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
- Streaming: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later, one per cycle, in_ready stays 1.
- Backpressure:
  - Stimulus: out_ready=0 while sending A=0xAAAA0000 then B=0xBBBB0000.
  - Required: out_data=A held; B goes to skid; in_ready=0. Raising out_ready -> A then B delivered in order, in_ready returns to 1 after B moves to main.
- Flush in SKID: with A and B held, pulse flush -> next cycle out_valid=0, out_ctrl=0, in_ready=1. Subsequently sending C=0x12345678 -> out_data=C only.
- Flush with concurrent input: flush=1, in_valid=1, in_data=0xDEAD -> 0xDEAD never appears on out_valid=1.
- PIPE_STALL_CNT_EN defined: out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF. Reset -> 0.
